fetch_inst_queue: RTL

- Instruction queue directly downstream of the PC/fetch stage.
- Each cycle it accepts one 128-bit fetch group from the instruction cache: up to 4 RV64 instructions, with the group PC and valid-instruction count produced by the PC stage.
- It unpacks the valid lanes into per-instruction entries and presents the two oldest instructions to the dual decoders.
- It is flushed on any redirect: decode1/decode2 jump correction or trap.

---
 rtl/fetch_inst_queue.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fetch_inst_queue.sv
// Instruction queue between the fetch stage and the dual decoders: unpacks a
// 128-bit fetch group into per-instruction entries and presents the two oldest.
module fetch_inst_queue #(
  parameter int DEPTH = 8,
  parameter int PCW   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PCW-1:0]         in_pc,
  input  logic [2:0]             in_count,
  input  logic [127:0]           in_inst,
  output logic                   out0_valid,
  output logic [PCW-1:0]         out0_pc,
  output logic [31:0]            out0_inst,
  output logic                   out1_valid,
  output logic [PCW-1:0]         out1_pc,
  output logic [31:0]            out1_inst,
  input  logic [1:0]             deq_count,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  // Handshake: a group transfers on a rising edge where in_valid & in_ready &
  // ~flush. in_ready depends only on registered occupancy, never on in_valid.
  logic [PCW-1:0] pc_mem   [DEPTH];
  logic [31:0]    inst_mem [DEPTH];

  logic [AW-1:0]  head;
  logic [AW-1:0]  tail;
  logic [OW-1:0]  occ_q;

  logic           fire;
  logic [1:0]     start_lane;
  logic [2:0]     lane_room;
  logic [2:0]     n_in;
  logic [1:0]     n_out;

  logic [3:0]     wr_en;
  logic [AW-1:0]  wr_idx  [4];
  logic [PCW-1:0] wr_pc   [4];
  logic [31:0]    wr_inst [4];
  logic [1:0]     wr_lane [4];

  logic [AW-1:0]  rd1_idx;

  assign in_ready   = (occ_q <= OW'(DEPTH - 4));
  assign fire       = in_valid & in_ready & ~flush;
  assign start_lane = in_pc[3:2];
  assign lane_room  = 3'd4 - {1'b0, start_lane};

  // Lanes before the start PC are dropped, and the group cannot run past lane 3.
  always_comb begin
    n_in = 3'd0;
    if (fire) begin
      n_in = (in_count < lane_room) ? in_count : lane_room;
    end
  end

  always_comb begin
    n_out = deq_count;
    if (OW'(deq_count) > occ_q) begin
      n_out = occ_q[1:0];
    end
  end

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      wr_en[j]   = (3'(j) < n_in);
      wr_idx[j]  = tail + AW'(j);
      wr_lane[j] = start_lane + 2'(j);
      wr_inst[j] = in_inst[32*wr_lane[j] +: 32];
      wr_pc[j]   = in_pc + PCW'(4 * j);
    end
  end

  // Entry storage carries no reset; valid-ness lives entirely in occ_q.
  always_ff @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      if (wr_en[j]) begin
        pc_mem[wr_idx[j]]   <= wr_pc[j];
        inst_mem[wr_idx[j]] <= wr_inst[j];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      occ_q <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      occ_q <= '0;
    end else begin
      head  <= head + AW'(n_out);
      tail  <= tail + AW'(n_in);
      occ_q <= occ_q + OW'(n_in) - OW'(n_out);
    end
  end

  assign rd1_idx    = head + AW'(1);
  assign occupancy  = occ_q;
  assign out0_valid = (occ_q >= OW'(1));
  assign out1_valid = (occ_q >= OW'(2));
  assign out0_pc    = out0_valid ? pc_mem[head]      : '0;
  assign out0_inst  = out0_valid ? inst_mem[head]    : '0;
  assign out1_pc    = out1_valid ? pc_mem[rd1_idx]   : '0;
  assign out1_inst  = out1_valid ? inst_mem[rd1_idx] : '0;

  occ_bound_a : assert property (@(posedge clk) disable iff (rst)
    occ_q <= OW'(DEPTH));

  ptr_consistent_a : assert property (@(posedge clk) disable iff (rst)
    AW'(head + occ_q[AW-1:0]) == tail);

endmodule
